// File: rtl/counter_cmd_sequencer.sv
// Valid/ready command sequencer driving a WIDTH-bit up/down counter (LOAD, UP N, DOWN N, NOP).
// Optional saturation at the count limits is enabled by defining CMD_SEQ_SAT_EN.
module counter_cmd_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic [WIDTH-1:0] cn,
  output logic             en,
  output logic             ud,
  output logic             load,
  output logic [WIDTH-1:0] cin,
  output logic             done,
  output logic             sat_hit
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  localparam logic [1:0]       OpLoad = 2'b00;
  localparam logic [1:0]       OpUp   = 2'b01;
  localparam logic [1:0]       OpDown = 2'b10;
  localparam logic [WIDTH-1:0] CntMax = '1;
  localparam logic [WIDTH-1:0] CntMin = '0;

  state_e           state;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] remaining;
  logic [WIDTH-1:0] shadow_step;
  logic             land_limit;
  logic             start_limit;

  assign cmd_ready = (state == StIdle) && rst;

  // Shadow follows the counter; ud is stable for the whole RUN phase.
  always_comb begin
    shadow_step = ud ? (shadow + WIDTH'(1)) : (shadow - WIDTH'(1));
  end

`ifdef CMD_SEQ_SAT_EN
  always_comb begin
    land_limit  = ud ? (shadow_step == CntMax) : (shadow_step == CntMin);
    start_limit = ((cmd_op == OpUp) && (cn == CntMax)) ||
                  ((cmd_op == OpDown) && (cn == CntMin));
  end
`else
  always_comb begin
    land_limit  = 1'b0;
    start_limit = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      en        <= 1'b0;
      ud        <= 1'b0;
      load      <= 1'b0;
      cin       <= '0;
      done      <= 1'b0;
      sat_hit   <= 1'b0;
      shadow    <= '0;
      remaining <= '0;
    end else begin
      done    <= 1'b0;
      sat_hit <= 1'b0;
      load    <= 1'b0;
      unique case (state)
        StIdle: begin
          if (cmd_valid) begin
            shadow    <= cn;
            remaining <= cmd_arg;
            case (cmd_op)
              OpLoad: begin
                load  <= 1'b1;
                cin   <= cmd_arg;
                state <= StLoad;
              end
              OpUp, OpDown: begin
                if (cmd_arg == '0) begin
                  done  <= 1'b1;
                  state <= StDone;
                end else if (start_limit) begin
                  done    <= 1'b1;
                  sat_hit <= 1'b1;
                  state   <= StDone;
                end else begin
                  en    <= 1'b1;
                  ud    <= (cmd_op == OpUp);
                  state <= StRun;
                end
              end
              default: begin
                done  <= 1'b1;
                state <= StDone;
              end
            endcase
          end
        end
        StLoad: begin
          shadow <= cin;
          done   <= 1'b1;
          state  <= StDone;
        end
        StRun: begin
          shadow    <= shadow_step;
          remaining <= remaining - WIDTH'(1);
          // Exit on the edge performing the final (or limit-reaching) step.
          if ((remaining == WIDTH'(1)) || land_limit) begin
            en      <= 1'b0;
            done    <= 1'b1;
            sat_hit <= land_limit;
            state   <= StDone;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Bench for counter_cmd_sequencer: drives it against a 4-bit up/down counter model, table vectors
// plus hand-written reset and back-to-back sequences; expectations switch on CMD_SEQ_SAT_EN.
module tb_counter_cmd_sequencer;

`ifdef CMD_SEQ_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpUp   = 2'b01;
  localparam logic [1:0] OpDown = 2'b10;
  localparam logic [1:0] OpNop  = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       cnt_rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_arg;
  logic [3:0] cn;
  logic       en;
  logic       ud;
  logic       load;
  logic [3:0] cin;
  logic       done;
  logic       sat_hit;

  int n_tests = 0;
  int n_fail  = 0;

  counter_cmd_sequencer #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_arg  (cmd_arg),
    .cn       (cn),
    .en       (en),
    .ud       (ud),
    .load     (load),
    .cin      (cin),
    .done     (done),
    .sat_hit  (sat_hit)
  );

  always #5 clk = ~clk;

  // Downstream counter: load has priority over en.
  always_ff @(posedge clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n)  cn <= 4'h0;
    else if (load)   cn <= cin;
    else if (en)     cn <= ud ? cn + 4'h1 : cn - 4'h1;
  end

  typedef struct {
    logic [1:0] op;
    logic [3:0] arg;
    int         en_c;
    int         ld_c;
    int         lat;
    logic [3:0] cn;
    logic       sat;
    logic       ud;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; returns at the negedge where done is seen.
  task automatic issue(input logic [1:0] op, input logic [3:0] arg, input bit hold,
                       output int en_cyc, output int ld_cyc, output int lat,
                       output logic sat, output logic busy_ok, output logic ud_seen);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    en_cyc    = 0;
    ld_cyc    = 0;
    lat       = -1;
    sat       = 1'b0;
    busy_ok   = 1'b1;
    ud_seen   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0 && !hold) cmd_valid = 1'b0;
      if (cmd_ready) busy_ok = 1'b0;
      en_cyc += int'(en);
      ld_cyc += int'(load);
      if (en) ud_seen = ud;
      if (done) begin
        lat = i;
        sat = sat_hit;
        break;
      end
    end
  endtask

  initial begin
    int   e_c;
    int   l_c;
    int   lt;
    logic st;
    logic bz;
    logic us;
    logic seen_done;

    vecs[0] = '{OpLoad, 4'hA, 0, 1, 1, 4'hA, 1'b0, 1'b0};
    vecs[1] = '{OpUp,   4'd8, Sat ? 5 : 8, 0, Sat ? 5 : 8, Sat ? 4'hF : 4'h2, Sat, 1'b1};
    vecs[2] = '{OpDown, 4'd0, 0, 0, 0, Sat ? 4'hF : 4'h2, 1'b0, 1'b0};
    vecs[3] = '{OpNop,  4'd5, 0, 0, 0, Sat ? 4'hF : 4'h2, 1'b0, 1'b0};
    vecs[4] = '{OpLoad, 4'h0, 0, 1, 1, 4'h0, 1'b0, 1'b0};
    vecs[5] = '{OpDown, 4'd1, Sat ? 0 : 1, 0, Sat ? 0 : 1, Sat ? 4'h0 : 4'hF, Sat, 1'b0};
    vecs[6] = '{OpLoad, 4'hE, 0, 1, 1, 4'hE, 1'b0, 1'b0};
    vecs[7] = '{OpUp,   4'd3, Sat ? 1 : 3, 0, Sat ? 1 : 3, Sat ? 4'hF : 4'h1, Sat, 1'b1};
    vecs[8] = '{OpDown, 4'd15, 15, 0, 15, Sat ? 4'h0 : 4'h2, Sat, 1'b0};

    // Reset held with a command present.
    rst       = 1'b0;
    cnt_rst_n = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OpLoad;
    cmd_arg   = 4'h5;
    repeat (3) @(negedge clk);
    cnt_rst_n = 1'b1;
    @(negedge clk);
    check("rst_en", en, 0);
    check("rst_ud", ud, 0);
    check("rst_load", load, 0);
    check("rst_cin", cin, 0);
    check("rst_done", done, 0);
    check("rst_sat", sat_hit, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_cn", cn, 0);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rel_ready", cmd_ready, 1);

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].arg, 1'b0, e_c, l_c, lt, st, bz, us);
      check($sformatf("v%0d_en_cycles", i), e_c, vecs[i].en_c);
      check($sformatf("v%0d_load_cycles", i), l_c, vecs[i].ld_c);
      check($sformatf("v%0d_latency", i), lt, vecs[i].lat);
      check($sformatf("v%0d_sat", i), st, vecs[i].sat);
      check($sformatf("v%0d_ud", i), us, vecs[i].ud);
      check($sformatf("v%0d_cn", i), cn, vecs[i].cn);
      check($sformatf("v%0d_busy_ready", i), bz, 1);
      @(negedge clk);
      check($sformatf("v%0d_ready_after", i), cmd_ready, 1);
      check($sformatf("v%0d_done_pulse", i), done, 0);
    end

    // Back-to-back with cmd_valid held high throughout.
    issue(OpLoad, 4'h3, 1'b1, e_c, l_c, lt, st, bz, us);
    check("b2b_load_lat", lt, 1);
    check("b2b_load_busy", bz, 1);
    check("b2b_load_cn", cn, 4'h3);
    cmd_op  = OpDown;
    cmd_arg = 4'd5;
    @(negedge clk);
    check("b2b_gap_ready", cmd_ready, 1);
    check("b2b_gap_en", en, 0);
    check("b2b_gap_load", load, 0);
    issue(OpDown, 4'd5, 1'b0, e_c, l_c, lt, st, bz, us);
    check("b2b_down_en", e_c, Sat ? 3 : 5);
    check("b2b_down_cn", cn, Sat ? 4'h0 : 4'hE);
    check("b2b_down_sat", st, Sat);
    check("b2b_down_busy", bz, 1);
    @(negedge clk);
    check("b2b_ready_after", cmd_ready, 1);

    // Reset in the middle of UP 10, after 4 counter steps.
    cmd_valid = 1'b1;
    cmd_op    = OpUp;
    cmd_arg   = 4'd10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) cmd_valid = 1'b0;
    end
    check("mid_en_before", en, 1);
    rst = 1'b0;
    #1;
    check("mid_en_dropped", en, 0);
    check("mid_ud_cleared", ud, 0);
    check("mid_ready_low", cmd_ready, 0);
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen_done |= done;
    end
    rst = 1'b1;
    @(negedge clk);
    seen_done |= done;
    check("mid_no_done", seen_done, 0);
    check("mid_cn_steps", cn, Sat ? 4'h4 : 4'h2);
    check("mid_ready_rel", cmd_ready, 1);
    issue(OpNop, 4'h0, 1'b0, e_c, l_c, lt, st, bz, us);
    check("post_nop_lat", lt, 0);
    @(negedge clk);
    issue(OpLoad, 4'h7, 1'b0, e_c, l_c, lt, st, bz, us);
    check("post_load_lat", lt, 1);
    check("post_load_cn", cn, 4'h7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
